panda_mtimer: RTL and testbench

PANDA_MTIMER -- requirements
Module: panda_mtimer

---
 rtl/panda_pkg.sv | 35 +++
 rtl/panda_prescaler.sv | 34 +++
 rtl/panda_mtimer.sv | 106 ++++++++++
 tb/tb_panda_mtimer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/panda_pkg.sv
// Shared types and constants for the panda machine timer.
package panda_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned PCNT_W      = 16;
  localparam int unsigned CTRL_EN_BIT = 0;
  localparam int unsigned CTRL_IE_BIT = 1;

  typedef enum logic [2:0] {
    REG_MTIME_LO    = 3'd0,
    REG_MTIME_HI    = 3'd1,
    REG_MTIMECMP_LO = 3'd2,
    REG_MTIMECMP_HI = 3'd3,
    REG_CTRL        = 3'd4
  } mtimer_reg_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      we;
  } data_req_t;

  // Replace the byte lanes of old_val whose enable bit is set.
  function automatic logic [XLEN-1:0] byte_merge(input logic [XLEN-1:0] old_val,
                                                 input logic [XLEN-1:0] new_val,
                                                 input logic [3:0]      be);
    logic [XLEN-1:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/panda_prescaler.sv
// Divides the core clock into mtime ticks; tick fires on the last count of each period.
module panda_prescaler
  import panda_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clear_i,
  output logic tick_c_o
);

  localparam logic [PCNT_W-1:0] LAST = PCNT_W'(PRESCALE - 1);

  logic [PCNT_W-1:0] cnt_q, cnt_d;

  assign tick_c_o = en_i & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_c_o ? '0 : cnt_q + PCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/panda_mtimer.sv
// Memory-mapped 64-bit machine timer with compare interrupt and byte-lane writes.
module panda_mtimer
  import panda_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] data_addr_i,
  input  logic [XLEN-1:0] data_wdata_i,
  input  logic [3:0]      data_we_i,
  output logic [XLEN-1:0] data_rdata_o,
  output logic            timer_irq_o
);

  data_req_t   req;
  logic        sel;
  logic        wr;
  logic [2:0]  reg_off;
  logic        unused_addr;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        irq_q, irq_d;
  logic        tick;
  logic        pre_clear;

  assign req         = {data_addr_i, data_wdata_i, data_we_i};
  assign sel         = (req.addr[31:5] == BASE_ADDR[31:5]);
  assign wr          = sel & (|req.we);
  assign reg_off     = req.addr[4:2];
  assign unused_addr = ^req.addr[1:0];
  assign timer_irq_o = irq_q;

  panda_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (en_q),
    .clear_i  (pre_clear),
    .tick_c_o (tick)
  );

  // Software writes to either mtime half override the tick increment.
  always_comb begin
    mtime_d    = mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    ie_d       = ie_q;
    pre_clear  = 1'b0;
    if (tick) mtime_d = mtime_q + 64'd1;
    if (wr) begin
      case (reg_off)
        REG_MTIME_LO:    mtime_d = {mtime_q[63:32], byte_merge(mtime_q[31:0], req.wdata, req.we)};
        REG_MTIME_HI:    mtime_d = {byte_merge(mtime_q[63:32], req.wdata, req.we), mtime_q[31:0]};
        REG_MTIMECMP_LO: mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0], req.wdata, req.we);
        REG_MTIMECMP_HI: mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], req.wdata, req.we);
        REG_CTRL: begin
          if (req.we[0]) begin
            en_d      = req.wdata[CTRL_EN_BIT];
            ie_d      = req.wdata[CTRL_IE_BIT];
            pre_clear = ~req.wdata[CTRL_EN_BIT];
          end
        end
        default: ;
      endcase
    end
    irq_d = ie_q & (mtime_q >= mtimecmp_q);
  end

  // Reads see pre-edge register contents.
  always_comb begin
    data_rdata_o = '0;
    if (sel) begin
      case (reg_off)
        REG_MTIME_LO:    data_rdata_o = mtime_q[31:0];
        REG_MTIME_HI:    data_rdata_o = mtime_q[63:32];
        REG_MTIMECMP_LO: data_rdata_o = mtimecmp_q[31:0];
        REG_MTIMECMP_HI: data_rdata_o = mtimecmp_q[63:32];
        REG_CTRL:        data_rdata_o = {30'd0, ie_q, en_q};
        default:         data_rdata_o = '0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      irq_q      <= irq_d;
    end
  end

endmodule

// File: tb/tb_panda_mtimer.sv
// Directed bench for panda_mtimer: register table plus timing corner sequences.
module tb_panda_mtimer;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic [31:0] rdata1, rdata4;
  logic        irq1, irq4;

  int unsigned n_pass;
  int unsigned n_total;

  typedef struct {
    logic [31:0] woff;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic [31:0] roff;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  panda_mtimer #(.BASE_ADDR(BASE), .PRESCALE(1)) dut1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_addr_i  (addr),
    .data_wdata_i (wdata),
    .data_we_i    (we),
    .data_rdata_o (rdata1),
    .timer_irq_o  (irq1)
  );

  panda_mtimer #(.BASE_ADDR(BASE), .PRESCALE(4)) dut4 (
    .clk_i        (clk),
    .rst_i        (rst),
    .data_addr_i  (addr),
    .data_wdata_i (wdata),
    .data_we_i    (we),
    .data_rdata_o (rdata4),
    .timer_irq_o  (irq4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Entered just after a negedge; consumes exactly one rising edge.
  task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [3:0] be);
    addr  = BASE + off;
    wdata = d;
    we    = be;
    @(negedge clk);
    we = '0;
  endtask

  task automatic rd(input logic [31:0] off);
    addr = BASE + off;
    we   = '0;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    we  = '0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    addr    = BASE;
    wdata   = '0;
    we      = '0;

    vecs[0] = '{32'h08, 32'h1234_5678, 4'hF,    32'h08, 32'h1234_5678};
    vecs[1] = '{32'h0E, 32'h00AA_0000, 4'b0100, 32'h0C, 32'hFFAA_FFFF};
    vecs[2] = '{32'h10, 32'hFFFF_FFFE, 4'hF,    32'h10, 32'h0000_0002};
    vecs[3] = '{32'h14, 32'hDEAD_BEEF, 4'hF,    32'h14, 32'h0000_0000};
    vecs[4] = '{32'h04, 32'h0000_0007, 4'hF,    32'h07, 32'h0000_0007};
    vecs[5] = '{32'h00, 32'hA5A5_A5A5, 4'b0001, 32'h00, 32'h0000_00A5};
    vecs[6] = '{32'h00, 32'hFFFF_FFFF, 4'b0000, 32'h00, 32'h0000_00A5};
    vecs[7] = '{32'h20, 32'h1111_1111, 4'hF,    32'h00, 32'h0000_00A5};
    vecs[8] = '{32'h1C, 32'h2222_2222, 4'hF,    32'h20, 32'h0000_0000};
    vecs[9] = '{32'h10, 32'h0000_0000, 4'hF,    32'h11, 32'h0000_0000};

    // Reset values are visible combinationally while reset is held.
    #1;
    check("rst_irq", 32'(irq1), 32'h0);
    rd(32'h00); check("rst_mtime_lo", rdata1, 32'h0);
    rd(32'h08); check("rst_cmp_lo", rdata1, 32'hFFFF_FFFF);
    rd(32'h0C); check("rst_cmp_hi", rdata1, 32'hFFFF_FFFF);
    rd(32'h10); check("rst_ctrl", rdata1, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Same-cycle read during a write returns the old value.
    addr = BASE + 32'h08; wdata = 32'h55; we = 4'hF;
    #1; check("rdw_old", rdata1, 32'hFFFF_FFFF);
    @(negedge clk); we = '0;
    #1; check("rdw_new", rdata1, 32'h0000_0055);

    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].woff, vecs[i].wdata, vecs[i].we);
      rd(vecs[i].roff);
      check($sformatf("vec%0d_p1", i), rdata1, vecs[i].exp);
      check($sformatf("vec%0d_p4", i), rdata4, vecs[i].exp);
    end

    // Free-running count, prescale divide, and counter clear on disable.
    do_reset();
    wr(32'h10, 32'h1, 4'hF);
    idle(10);
    rd(32'h00); check("cnt10_lo", rdata1, 32'd10);
    check("pre4_lo", rdata4, 32'd2);
    rd(32'h04); check("cnt10_hi", rdata1, 32'd0);
    wr(32'h10, 32'h0, 4'hF);
    idle(5);
    rd(32'h00); check("hold_p1", rdata1, 32'd11);
    check("hold_p4", rdata4, 32'd2);
    wr(32'h10, 32'h1, 4'hF);
    idle(3);
    rd(32'h00); check("restart_3cyc", rdata4, 32'd2);
    idle(1);
    rd(32'h00); check("restart_4cyc", rdata4, 32'd3);

    // Carry from LO into HI, and full 64-bit wrap.
    do_reset();
    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(32'h04, 32'h0, 4'hF);
    wr(32'h10, 32'h1, 4'hF);
    idle(1);
    rd(32'h00); check("carry_lo", rdata1, 32'h0);
    rd(32'h04); check("carry_hi", rdata1, 32'h1);
    wr(32'h10, 32'h0, 4'hF);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF);
    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(32'h10, 32'h1, 4'hF);
    idle(1);
    rd(32'h00); check("wrap_lo", rdata1, 32'h0);
    rd(32'h04); check("wrap_hi", rdata1, 32'h0);

    // Compare interrupt rise and fall.
    do_reset();
    wr(32'h08, 32'd5, 4'hF);
    wr(32'h0C, 32'd0, 4'hF);
    wr(32'h10, 32'h3, 4'hF);
    idle(5);
    rd(32'h00); check("irq_mtime5", rdata1, 32'd5);
    check("irq_not_yet", 32'(irq1), 32'h0);
    idle(1);
    check("irq_rise", 32'(irq1), 32'h1);
    wr(32'h08, 32'd100, 4'hF);
    check("irq_hold_edge", 32'(irq1), 32'h1);
    idle(1);
    check("irq_fall_cmp", 32'(irq1), 32'h0);
    wr(32'h08, 32'd0, 4'hF);
    idle(1);
    check("irq_rise2", 32'(irq1), 32'h1);
    wr(32'h10, 32'h1, 4'hF);
    check("irq_ie_edge", 32'(irq1), 32'h1);
    idle(1);
    check("irq_fall_ie", 32'(irq1), 32'h0);

    // Partial byte write to mtime on a tick edge wins over the increment.
    do_reset();
    wr(32'h00, 32'h0000_1200, 4'hF);
    wr(32'h10, 32'h1, 4'hF);
    wr(32'h00, 32'h0000_AB00, 4'b0010);
    rd(32'h00); check("bytewr_lo", rdata1, 32'h0000_AB00);
    wr(32'h04, 32'h5, 4'hF);
    rd(32'h00); check("hiwr_lo_keep", rdata1, 32'h0000_AB00);
    rd(32'h04); check("hiwr_hi", rdata1, 32'h5);
    idle(1);
    rd(32'h00); check("resume_lo", rdata1, 32'h0000_AB01);

    // Reset asserted mid-count with the interrupt pending.
    do_reset();
    wr(32'h08, 32'h0, 4'hF);
    wr(32'h0C, 32'h0, 4'hF);
    wr(32'h10, 32'h3, 4'hF);
    idle(2);
    check("pre_rst_irq1", 32'(irq1), 32'h1);
    check("pre_rst_irq4", 32'(irq4), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_irq1", 32'(irq1), 32'h0);
    check("async_irq4", 32'(irq4), 32'h0);
    rd(32'h00); check("async_mtime_lo", rdata1, 32'h0);
    rd(32'h04); check("async_mtime_hi", rdata1, 32'h0);
    rd(32'h08); check("async_cmp_lo", rdata1, 32'hFFFF_FFFF);
    rd(32'h0C); check("async_cmp_hi", rdata1, 32'hFFFF_FFFF);
    rd(32'h18); check("unmapped_18", rdata1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    wr(32'h10, 32'h1, 4'hF);
    idle(3);
    rd(32'h00); check("post_rst_3cyc", rdata4, 32'd0);
    idle(1);
    rd(32'h00); check("post_rst_4cyc", rdata4, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
